store_trace_buffer: RTL and testbench

- Sits directly downstream of the MIPS `top` store bus (`memwrite`, `dataadr`, `writedata`).
- Captures every qualifying data-memory store into a small first-word-fall-through (FWFT) FIFO.
- A bench or debug port drains the FIFO over a valid/ready handshake, so store order and values can be checked without sampling on a clock edge.
- Also keeps a saturating store counter and sticky error flags (overflow, misaligned).

---
 rtl/store_trace_pkg.sv | 21 ++
 rtl/sync_fifo_fwft.sv | 67 ++++++
 rtl/store_trace_buffer.sv | 98 +++++++++
 tb/tb_store_trace_buffer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/store_trace_pkg.sv
// Shared types and helpers for the store trace buffer.
//   store_entry_t : one captured store {byte address, store data}
//   ADR_LO_DEF/ADR_HI_DEF : default capture window (inclusive byte addresses)
//   in_window()   : unsigned inclusive window test
package store_trace_pkg;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } store_entry_t;

  localparam logic [31:0] ADR_LO_DEF = 32'h0000_0000;
  localparam logic [31:0] ADR_HI_DEF = 32'h0000_00FF;

  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (adr >= lo) && (adr <= hi);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with separate occupancy counter.
//   clk, reset : clock, async active-high reset (pointers/level to 0)
//   i_push/i_din : write request and data; honoured when not full, or when
//                  full and a pop happens in the same cycle
//   i_pop      : read request; ignored while empty
//   o_dout     : head entry, zero while empty
//   o_full/o_empty/o_level : occupancy status
module sync_fifo_fwft
  import store_trace_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = store_entry_t,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  T            i_din,
  input  logic        i_pop,
  output T            o_dout,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == FULL_LVL);
  assign o_level = r_level;

  // A full FIFO can still accept a write when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  assign o_dout = o_empty ? '0 : r_mem[r_rptr];

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // Pointers are log2(DEPTH) wide, so +1 wraps modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/store_trace_buffer.sv
// Captures in-window data-memory stores from the core store bus into a FWFT
// FIFO drained over valid/ready, with a saturating store counter and sticky
// overflow/misaligned flags.
//   clk, reset            : core clock, async active-high reset
//   memwrite/dataadr/writedata : core store bus
//   rd_valid/rd_ready/rd_adr/rd_data : drain port (head of FIFO)
//   level                 : FIFO occupancy
//   store_count           : qualifying stores seen, saturating
//   overflow, misaligned  : sticky error flags
//   clear_flags           : sync clear of flags and counter (same-cycle events win)
module store_trace_buffer
  import store_trace_pkg::*;
#(
  parameter int          DEPTH  = 8,
  parameter logic [31:0] ADR_LO = ADR_LO_DEF,
  parameter logic [31:0] ADR_HI = ADR_HI_DEF,
  parameter int          CNT_W  = 16,
  localparam int         LW     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_adr,
  output logic [31:0]      rd_data,
  output logic [LW-1:0]    level,
  output logic [CNT_W-1:0] store_count,
  output logic             overflow,
  output logic             misaligned,
  input  logic             clear_flags
);

  logic         w_we;
  logic         w_qual;
  logic         w_aligned;
  logic         w_push_req;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic         w_drop;
  logic         w_mis_evt;
  store_entry_t w_din;
  store_entry_t w_head;

  // An if() on an unknown strobe takes the else path, so X reads as no store
  // and never reaches the FIFO pointers.
  always_comb begin
    w_we = 1'b0;
    if (memwrite) w_we = 1'b1;
  end

  assign w_qual     = w_we && in_window(dataadr, ADR_LO, ADR_HI);
  assign w_aligned  = (dataadr[1:0] == 2'b00);
  assign w_push_req = w_qual && w_aligned;
  assign w_mis_evt  = w_qual && !w_aligned;
  assign w_pop      = rd_valid && rd_ready;
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_din      = '{adr: dataadr, data: writedata};

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .T     (store_entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_req),
    .i_din   (w_din),
    .i_pop   (rd_ready),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign rd_valid = !w_empty;
  assign rd_adr   = w_head.adr;
  assign rd_data  = w_head.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_count <= '0;
      overflow    <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      // Clear first, then let this cycle's events land on top.
      overflow   <= (overflow   && !clear_flags) || w_drop;
      misaligned <= (misaligned && !clear_flags) || w_mis_evt;
      if (clear_flags)
        store_count <= CNT_W'(w_qual);
      else if (w_qual && !(&store_count))
        store_count <= store_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_store_trace_buffer.sv
module tb_store_trace_buffer;
  import store_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;  // narrow so saturation is reachable
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             memwrite = 1'b0;
  logic [31:0]      dataadr = '0;
  logic [31:0]      writedata = '0;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [31:0]      rd_adr;
  logic [31:0]      rd_data;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] store_count;
  logic             overflow;
  logic             misaligned;
  logic             clear_flags = 1'b0;

  always #5 clk = ~clk;

  store_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_adr(rd_adr), .rd_data(rd_data), .level(level),
    .store_count(store_count), .overflow(overflow), .misaligned(misaligned),
    .clear_flags(clear_flags)
  );

  // Reference model: queue of captured stores plus counter and flags.
  store_entry_t q[$];
  int           m_cnt;
  bit           m_ov;
  bit           m_mis;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("rd_valid",    64'(rd_valid),    64'(q.size() != 0));
    chk("rd_adr",      64'(rd_adr),      q.size() != 0 ? 64'(q[0].adr)  : 64'd0);
    chk("rd_data",     64'(rd_data),     q.size() != 0 ? 64'(q[0].data) : 64'd0);
    chk("level",       64'(level),       64'(q.size()));
    chk("store_count", 64'(store_count), 64'(m_cnt));
    chk("overflow",    64'(overflow),    64'(m_ov));
    chk("misaligned",  64'(misaligned),  64'(m_mis));
  endtask

  task automatic model_clear();
    q.delete();
    m_cnt = 0;
    m_ov  = 0;
    m_mis = 0;
  endtask

  // One clock: drive inputs on the falling edge, advance the model with the
  // rules for that edge, then compare just after the rising edge.
  task automatic step(input bit mw, input logic [31:0] a, input logic [31:0] d,
                      input bit rdy, input bit clr);
    bit qual, pop;
    @(negedge clk);
    memwrite = mw; dataadr = a; writedata = d; rd_ready = rdy; clear_flags = clr;
    qual = mw && (a >= ADR_LO_DEF) && (a <= ADR_HI_DEF);
    pop  = rdy && (q.size() != 0);
    if (clr) begin m_cnt = 0; m_ov = 0; m_mis = 0; end
    if (pop) void'(q.pop_front());
    if (qual) begin
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (a[1:0] != 2'b00) m_mis = 1;
      else if (q.size() < DEPTH) q.push_back('{adr: a, data: d});
      else m_ov = 1;
    end
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'h0, 32'h0, rdy, 1'b0);
  endtask

  task automatic sync_reset();
    @(negedge clk);
    memwrite = 1'b0; rd_ready = 1'b0; clear_flags = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    chk_all();
  endtask

  int          t1_adr [5] = '{52, 32, 28, 24, 20};
  int          t1_dat [5] = '{1, 3, 6, 9, 28};
  logic [31:0] ra;

  initial begin
    model_clear();
    // Reset state
    reset = 1'b1;
    #3;
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_adr", 64'(rd_adr), 64'd0);
    chk("rst_flags", {overflow, misaligned, store_count}, 64'd0);
    #4 reset = 1'b0;
    chk_all();

    // Five stores back to back, then drain in order
    for (int i = 0; i < 5; i++) step(1'b1, t1_adr[i], t1_dat[i], 1'b0, 1'b0);
    chk("t1_level", 64'(level), 64'd5);
    chk("t1_count", 64'(store_count), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t1_head_adr", 64'(rd_adr), 64'(t1_adr[i]));
      chk("t1_head_dat", 64'(rd_data), 64'(t1_dat[i]));
      idle(1'b1);
    end
    chk("t1_empty", 64'(rd_valid), 64'd0);

    // Overflow: nine stores into an 8-deep FIFO
    sync_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 32'(4 * i + 64), 32'(100 + i), 1'b0, 1'b0);
    chk("t2_level", 64'(level), 64'd8);
    chk("t2_ovf", 64'(overflow), 64'd1);
    chk("t2_count", 64'(store_count), 64'd9);

    // clear_flags with a simultaneous store while full and popping
    step(1'b1, 32'd40, 32'hC0DE, 1'b1, 1'b1);
    chk("t6_count", 64'(store_count), 64'd1);
    chk("t6_ovf", 64'(overflow), 64'd0);
    chk("t6_level", 64'(level), 64'd8);
    for (int i = 1; i < 8; i++) begin
      chk("t2_drain_adr", 64'(rd_adr), 64'(4 * i + 64));
      idle(1'b1);
    end
    chk("t6_tail_adr", 64'(rd_adr), 64'd40);
    idle(1'b1);

    // Full FIFO, push and pop in the same cycle
    sync_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 32'(4 * i), 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'd40, 32'h40, 1'b1, 1'b0);
    chk("t3_level", 64'(level), 64'd8);
    chk("t3_ovf", 64'(overflow), 64'd0);
    chk("t3_head", 64'(rd_adr), 64'd4);
    for (int i = 0; i < 8; i++) idle(1'b1);

    // Out-of-window and misaligned stores
    sync_reset();
    step(1'b1, 32'h100, 32'h1, 1'b0, 1'b0);
    chk("t4_oow_count", 64'(store_count), 64'd0);
    chk("t4_oow_level", 64'(level), 64'd0);
    step(1'b1, 32'h31, 32'h2, 1'b0, 1'b0);
    chk("t4_mis_flag", 64'(misaligned), 64'd1);
    chk("t4_mis_count", 64'(store_count), 64'd1);
    chk("t4_mis_level", 64'(level), 64'd0);

    // Empty with push and rd_ready together: push only
    step(1'b1, 32'h10, 32'h77, 1'b1, 1'b0);
    chk("t7_level", 64'(level), 64'd1);
    idle(1'b1);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) step(1'b1, 32'(8 * i), 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h33, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("t5_valid", 64'(rd_valid), 64'd0);
    chk("t5_level", 64'(level), 64'd0);
    #2;
    reset = 1'b0;
    model_clear();
    chk("t5_flags", {overflow, misaligned, store_count}, 64'd0);
    chk_all();

    // Randomized traffic including out-of-window, misaligned, clears, saturation
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 32'h13F));
      else ra = {22'd0, 8'($urandom_range(0, 79)), 2'b00};
      step(1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 40) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
